// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and
// op-class predicates used by both the arithmetic core and the top level.
package md_pkg;

   localparam logic [3:0] OP_MULT  = 4'b0000;
   localparam logic [3:0] OP_MULTU = 4'b0001;
   localparam logic [3:0] OP_DIV   = 4'b0010;
   localparam logic [3:0] OP_DIVU  = 4'b0011;
   localparam logic [3:0] OP_MFHI  = 4'b0100;
   localparam logic [3:0] OP_MFLO  = 4'b0101;
   localparam logic [3:0] OP_MTHI  = 4'b0110;
   localparam logic [3:0] OP_MTLO  = 4'b0111;
   localparam logic [3:0] OP_MADD  = 4'b1000;
   localparam logic [3:0] OP_MADDU = 4'b1001;
   localparam logic [3:0] OP_MSUB  = 4'b1010;
   localparam logic [3:0] OP_MSUBU = 4'b1011;

   // Plain multiply: result replaces {HI,LO}.
   function automatic logic is_mul_class(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   // Divide: HI gets the remainder, LO the quotient.
   function automatic logic is_div_class(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Multiply-accumulate / multiply-subtract into {HI,LO}.
   function automatic logic is_acc_class(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational arithmetic core: produces the pending {HI,LO} value for
// multiply, multiply-accumulate/subtract and divide operations.
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [WIDTH-1:0]   hi,
   input  logic [WIDTH-1:0]   lo,
   output logic [2*WIDTH-1:0] res
);

   logic               sgn;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic [2*WIDTH-1:0] prod;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   // Product, signed divide by magnitudes, then select by op class.
   always_comb begin
      // Bit 0 clear marks the signed variant of every arithmetic op.
      sgn   = !op[0];
      // Extending to 2W bits and keeping the low 2W bits of the product
      // gives the correct signed or unsigned result modulo 2^(2W).
      a_ext = sgn ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
      b_ext = sgn ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};
      prod  = a_ext * b_ext;

      a_neg  = sgn && in_a[WIDTH-1];
      b_neg  = sgn && in_b[WIDTH-1];
      a_mag  = a_neg ? -in_a : in_a;
      b_mag  = b_neg ? -in_b : in_b;
      // Zero divisors are never accepted; avoid a meaningless divide here.
      b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      // MIN/-1 wraps back to MIN with remainder 0 naturally.
      quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem    = a_neg ? -r_mag : r_mag;

      res = {hi, lo};
      if (is_mul_class(op)) begin
         res = prod;
      end else if (is_acc_class(op)) begin
         res = op[1] ? ({hi, lo} - prod) : ({hi, lo} + prod);
      end else if (is_div_class(op)) begin
         res = {rem, quot};
      end
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers. Results are computed at accept
// time, held in pending registers, and committed when the latency counter
// expires; busy stalls the pipeline meanwhile.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             busy,
   output logic [WIDTH-1:0] rd_out
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [2*WIDTH-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q;
   logic               accept;
   logic [2*WIDTH-1:0] arith_res;

   md_arith #(.WIDTH(WIDTH)) u_arith (
      .op   (op),
      .in_a (in_a),
      .in_b (in_b),
      .hi   (hi_q),
      .lo   (lo_q),
      .res  (arith_res)
   );

   assign accept = start && !flush && !busy_q;
   assign busy   = busy_q;

   // Next-state: count down and commit in flight, otherwise accept a new op.
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      pend_d = pend_q;
      cnt_d  = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            hi_d = pend_q[2*WIDTH-1:WIDTH];
            lo_d = pend_q[WIDTH-1:0];
         end
      end else if (accept) begin
         if (is_mul_class(op) || is_acc_class(op)) begin
            pend_d = arith_res;
            cnt_d  = CNT_W'(MUL_CYCLES);
         end else if (is_div_class(op) && (in_b != '0)) begin
            pend_d = arith_res;
            cnt_d  = CNT_W'(DIV_CYCLES);
         end else if (op == OP_MTHI) begin
            hi_d = in_a;
         end else if (op == OP_MTLO) begin
            lo_d = in_a;
         end
      end
   end

   // State registers; busy is registered straight from the next count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         pend_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         busy_q <= (cnt_d != '0);
      end
   end

   // Read port for MFHI/MFLO; zero for every other op.
   always_comb begin
      rd_out = '0;
      if (op == OP_MFHI) begin
         rd_out = hi_q;
      end else if (op == OP_MFLO) begin
         rd_out = lo_q;
      end
   end

endmodule
